park_gate_ctrl: RTL and testbench

- Sequential controller for the parking-lot datapath. Owns the occupancy bitmap and arbitrates between the entry lane and the exit lane. Assigns the lowest free slot to an entering car, frees the slot of a leaving car, and drives one shared barrier gate with a timeout.
- Sits between the lane sensors/buttons and the display and slot logic. The occupancy bitmap it exports is the capacity vector consumed downstream.

---
 rtl/park_gate_ctrl_pkg.sv | 29 ++
 rtl/park_gate_ctrl_if.sv | 48 ++++
 rtl/park_gate_ctrl_free_slot_finder.sv | 23 ++
 rtl/park_gate_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_park_gate_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/park_gate_ctrl_pkg.sv
// park_pkg: lot sizing, controller state and lane-priority encodings, and the
// free-slot popcount shared by park_gate_ctrl and its slot finder.
package park_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_GATE = 2'd1,
    EXIT_GATE  = 2'd2
  } state_e;

  typedef enum logic {
    PRIO_EXIT  = 1'b0,
    PRIO_ENTRY = 1'b1
  } prio_e;

  // Number of zero bits in an occupancy vector.
  function automatic logic [SLOT_W:0] count_free(input logic [NUM_SLOTS-1:0] occ);
    logic [SLOT_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n = n + {{SLOT_W{1'b0}}, ~occ[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/park_gate_ctrl_if.sv
// park_gate_ctrl_if: signal bundle between the lane sensors/buttons, the
// controller and the display/slot logic.
//   master : lane side (drives requests, exit slot and the gate sensor)
//   slave  : park_gate_ctrl
// Build macro PARK_GATE_STATS_EN adds the stat_* counter outputs.
interface park_gate_ctrl_if;
  import park_pkg::*;

  logic                 entry_req;
  logic                 exit_req;
  logic [SLOT_W-1:0]    exit_slot;
  logic                 car_passed;

  logic                 entry_ack;
  logic                 entry_reject;
  logic                 exit_ack;
  logic                 err_exit;
  logic [SLOT_W-1:0]    assigned_slot;
  logic                 gate_open;
  logic [NUM_SLOTS-1:0] occupancy;
  logic [SLOT_W:0]      free_count;
  logic                 full;
  logic                 busy;
`ifdef PARK_GATE_STATS_EN
  logic [15:0]          stat_entries;
  logic [15:0]          stat_rejects;
  logic [15:0]          stat_timeouts;
`endif

  modport master (
    output entry_req, exit_req, exit_slot, car_passed,
`ifdef PARK_GATE_STATS_EN
    input  stat_entries, stat_rejects, stat_timeouts,
`endif
    input  entry_ack, entry_reject, exit_ack, err_exit, assigned_slot,
           gate_open, occupancy, free_count, full, busy
  );

  modport slave (
    input  entry_req, exit_req, exit_slot, car_passed,
`ifdef PARK_GATE_STATS_EN
    output stat_entries, stat_rejects, stat_timeouts,
`endif
    output entry_ack, entry_reject, exit_ack, err_exit, assigned_slot,
           gate_open, occupancy, free_count, full, busy
  );

endinterface

// File: rtl/park_gate_ctrl_free_slot_finder.sv
// free_slot_finder: combinational search for the lowest-index free slot.
// o_any_free is low when every slot is occupied; o_free_idx is then 0.
module free_slot_finder
  import park_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] i_occupancy,
  output logic [SLOT_W-1:0]    o_free_idx,
  output logic                 o_any_free
);

  // Scan from the top down so the last hit written is the lowest free index.
  always_comb begin
    o_free_idx = '0;
    o_any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!i_occupancy[i]) begin
        o_free_idx = SLOT_W'(i);
        o_any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/park_gate_ctrl.sv
// park_gate_ctrl: parking-lot gate controller. Owns the occupancy bitmap,
// arbitrates the entry and exit lanes, and drives the shared barrier gate
// with a timeout. Every output is registered.
// Build macro PARK_GATE_STATS_EN adds saturating entry/reject/timeout counters.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | gate closed, lane requests sampled and arbitrated
//   ENTRY_GATE | gate open for an entering car; slot already marked occupied,
//              | released again if the car never passes
//   EXIT_GATE  | gate open for a leaving car; slot released when it passes
module park_gate_ctrl
  import park_pkg::*;
#(
  parameter int GATE_TIMEOUT = 100,
  parameter int TIMER_W      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  park_gate_ctrl_if.slave bus
);

  localparam logic [1:0]         S_IDLE       = IDLE;
  localparam logic [1:0]         S_ENTRY_GATE = ENTRY_GATE;
  localparam logic [1:0]         S_EXIT_GATE  = EXIT_GATE;
  localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(GATE_TIMEOUT - 1);

  logic [1:0]           r_state,         w_state_nxt;
  prio_e                r_prio,          w_prio_nxt;
  logic [TIMER_W-1:0]   r_timer,         w_timer_nxt;
  logic [NUM_SLOTS-1:0] r_occupancy,     w_occ_nxt;
  logic [SLOT_W-1:0]    r_assigned_slot, w_assigned_nxt;
  logic [SLOT_W-1:0]    r_exit_slot,     w_exit_slot_nxt;
  logic                 r_gate_open,     w_gate_nxt;
  logic                 r_entry_ack,     w_entry_ack_nxt;
  logic                 r_entry_reject,  w_entry_reject_nxt;
  logic                 r_exit_ack,      w_exit_ack_nxt;
  logic                 r_err_exit,      w_err_exit_nxt;
  logic [SLOT_W:0]      r_free_count,    w_free_count_nxt;
  logic                 r_full,          w_full_nxt;
  logic                 r_busy;

  logic [SLOT_W-1:0]    w_free_idx;
  logic                 w_any_free;
  logic                 w_serve_entry;
  logic                 w_serve_exit;
  logic                 w_timeout;

  free_slot_finder u_free_slot_finder (
    .i_occupancy (r_occupancy),
    .o_free_idx  (w_free_idx),
    .o_any_free  (w_any_free)
  );

  // prio only decides when both lanes ask in the same cycle.
  assign w_serve_entry = bus.entry_req & (~bus.exit_req | (r_prio == PRIO_ENTRY));
  assign w_serve_exit  = bus.exit_req & ~w_serve_entry;

  // Gate times out on its last counted cycle unless the car passes then.
  assign w_timeout = (r_state != S_IDLE) & ~bus.car_passed & (r_timer == TIMER_LAST);

  // Flags track the occupancy that is about to be registered.
  assign w_free_count_nxt = count_free(w_occ_nxt);
  assign w_full_nxt       = &w_occ_nxt;

  // Next-state, bitmap and pulse decode.
  always_comb begin
    w_state_nxt        = r_state;
    w_prio_nxt         = r_prio;
    w_timer_nxt        = r_timer;
    w_occ_nxt          = r_occupancy;
    w_assigned_nxt     = r_assigned_slot;
    w_exit_slot_nxt    = r_exit_slot;
    w_gate_nxt         = r_gate_open;
    w_entry_ack_nxt    = 1'b0;
    w_entry_reject_nxt = 1'b0;
    w_exit_ack_nxt     = 1'b0;
    w_err_exit_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_serve_entry) begin
          w_prio_nxt = PRIO_EXIT;
          if (w_any_free) begin
            w_occ_nxt[w_free_idx] = 1'b1;
            w_assigned_nxt        = w_free_idx;
            w_entry_ack_nxt       = 1'b1;
            w_gate_nxt            = 1'b1;
            w_timer_nxt           = '0;
            w_state_nxt           = S_ENTRY_GATE;
          end else begin
            w_entry_reject_nxt = 1'b1;
          end
        end else if (w_serve_exit) begin
          w_prio_nxt = PRIO_ENTRY;
          if (r_occupancy[bus.exit_slot]) begin
            // Bit stays set until the car actually leaves.
            w_exit_slot_nxt = bus.exit_slot;
            w_exit_ack_nxt  = 1'b1;
            w_gate_nxt      = 1'b1;
            w_timer_nxt     = '0;
            w_state_nxt     = S_EXIT_GATE;
          end else begin
            w_err_exit_nxt = 1'b1;
          end
        end
      end

      S_ENTRY_GATE: begin
        if (bus.car_passed) begin
          w_gate_nxt  = 1'b0;
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          // Car never came in: hand the slot back.
          w_occ_nxt[r_assigned_slot] = 1'b0;
          w_gate_nxt                 = 1'b0;
          w_timer_nxt                = '0;
          w_state_nxt                = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end

      S_EXIT_GATE: begin
        if (bus.car_passed) begin
          w_occ_nxt[r_exit_slot] = 1'b0;
          w_gate_nxt             = 1'b0;
          w_timer_nxt            = '0;
          w_state_nxt            = S_IDLE;
        end else if (w_timeout) begin
          // Car stayed inside: slot remains occupied.
          w_gate_nxt  = 1'b0;
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end

      default: begin
        w_gate_nxt  = 1'b0;
        w_timer_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset closes the gate and forgets the lot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_prio          <= PRIO_EXIT;
      r_timer         <= '0;
      r_occupancy     <= '0;
      r_assigned_slot <= '0;
      r_exit_slot     <= '0;
      r_gate_open     <= 1'b0;
      r_entry_ack     <= 1'b0;
      r_entry_reject  <= 1'b0;
      r_exit_ack      <= 1'b0;
      r_err_exit      <= 1'b0;
      r_free_count    <= (SLOT_W + 1)'(NUM_SLOTS);
      r_full          <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_prio          <= w_prio_nxt;
      r_timer         <= w_timer_nxt;
      r_occupancy     <= w_occ_nxt;
      r_assigned_slot <= w_assigned_nxt;
      r_exit_slot     <= w_exit_slot_nxt;
      r_gate_open     <= w_gate_nxt;
      r_entry_ack     <= w_entry_ack_nxt;
      r_entry_reject  <= w_entry_reject_nxt;
      r_exit_ack      <= w_exit_ack_nxt;
      r_err_exit      <= w_err_exit_nxt;
      r_free_count    <= w_free_count_nxt;
      r_full          <= w_full_nxt;
      r_busy          <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.entry_ack     = r_entry_ack;
  assign bus.entry_reject  = r_entry_reject;
  assign bus.exit_ack      = r_exit_ack;
  assign bus.err_exit      = r_err_exit;
  assign bus.assigned_slot = r_assigned_slot;
  assign bus.gate_open     = r_gate_open;
  assign bus.occupancy     = r_occupancy;
  assign bus.free_count    = r_free_count;
  assign bus.full          = r_full;
  assign bus.busy          = r_busy;

`ifdef PARK_GATE_STATS_EN
  logic [15:0] r_stat_entries;
  logic [15:0] r_stat_rejects;
  logic [15:0] r_stat_timeouts;

  // Saturating event counters for service statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_entries  <= '0;
      r_stat_rejects  <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (w_entry_ack_nxt && (r_stat_entries != 16'hFFFF)) begin
        r_stat_entries <= r_stat_entries + 16'd1;
      end
      if (w_entry_reject_nxt && (r_stat_rejects != 16'hFFFF)) begin
        r_stat_rejects <= r_stat_rejects + 16'd1;
      end
      if (w_timeout && (r_stat_timeouts != 16'hFFFF)) begin
        r_stat_timeouts <= r_stat_timeouts + 16'd1;
      end
    end
  end

  assign bus.stat_entries  = r_stat_entries;
  assign bus.stat_rejects  = r_stat_rejects;
  assign bus.stat_timeouts = r_stat_timeouts;
`endif

endmodule

// File: tb/tb_park_gate_ctrl.sv
// tb_park_gate_ctrl: directed scenarios plus randomized lane traffic, checked
// every cycle against a lot-level model (slot set, gate owner, open time).
`timescale 1ns/100ps
module tb_park_gate_ctrl;
  import park_pkg::*;

  localparam int GATE_TIMEOUT = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  park_gate_ctrl_if bus ();

  park_gate_ctrl #(.GATE_TIMEOUT(GATE_TIMEOUT), .TIMER_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [NUM_SLOTS-1:0] m_occ;
  bit m_open;            // gate currently open
  bit m_open_for_entry;  // which lane owns the open gate
  int m_open_cycles;     // edges elapsed since the gate opened
  bit m_next_is_exit;    // lane preferred on a tie
  int m_slot;
  int m_exit_slot;
  bit m_eack, m_erej, m_xack, m_xerr;
  int m_entries, m_rejects, m_timeouts;

  function automatic void model_reset();
    m_occ = '0; m_open = 0; m_open_for_entry = 0; m_open_cycles = 0;
    m_next_is_exit = 1; m_slot = 0; m_exit_slot = 0;
    m_eack = 0; m_erej = 0; m_xack = 0; m_xerr = 0;
    m_entries = 0; m_rejects = 0; m_timeouts = 0;
  endfunction

  task automatic model_step(input bit er, input bit xr, input int xs, input bit cp);
    int free_q[$];
    bit take_entry;
    m_eack = 0; m_erej = 0; m_xack = 0; m_xerr = 0;
    if (!m_open) begin
      take_entry = er && !(xr && m_next_is_exit);
      if (take_entry) begin
        for (int i = 0; i < NUM_SLOTS; i++) if (!m_occ[i]) free_q.push_back(i);
        if (free_q.size() > 0) begin
          m_slot = free_q[0];
          m_occ[m_slot] = 1'b1;
          m_eack = 1; m_open = 1; m_open_for_entry = 1; m_open_cycles = 0;
          if (m_entries < 65535) m_entries++;
        end else begin
          m_erej = 1;
          if (m_rejects < 65535) m_rejects++;
        end
        m_next_is_exit = 1;
      end else if (xr) begin
        if (m_occ[xs]) begin
          m_xack = 1; m_open = 1; m_open_for_entry = 0; m_open_cycles = 0;
          m_exit_slot = xs;
        end else begin
          m_xerr = 1;
        end
        m_next_is_exit = 0;
      end
    end else begin
      m_open_cycles++;
      if (cp) begin
        if (!m_open_for_entry) m_occ[m_exit_slot] = 1'b0;
        m_open = 0;
      end else if (m_open_cycles == GATE_TIMEOUT) begin
        if (m_open_for_entry) m_occ[m_slot] = 1'b0;
        m_open = 0;
        if (m_timeouts < 65535) m_timeouts++;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step(bus.entry_req, bus.exit_req, int'(bus.exit_slot), bus.car_passed);
  end

  always @(negedge rst_n) model_reset();

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("entry_ack",     int'(bus.entry_ack),     int'(m_eack));
    check("entry_reject",  int'(bus.entry_reject),  int'(m_erej));
    check("exit_ack",      int'(bus.exit_ack),      int'(m_xack));
    check("err_exit",      int'(bus.err_exit),      int'(m_xerr));
    check("assigned_slot", int'(bus.assigned_slot), m_slot);
    check("gate_open",     int'(bus.gate_open),     int'(m_open));
    check("busy",          int'(bus.busy),          int'(m_open));
    check("occupancy",     int'(bus.occupancy),     int'(m_occ));
    check("free_count",    int'(bus.free_count),    NUM_SLOTS - $countones(m_occ));
    check("full",          int'(bus.full),          int'(m_occ == '1));
`ifdef PARK_GATE_STATS_EN
    check("stat_entries",  int'(bus.stat_entries),  m_entries);
    check("stat_rejects",  int'(bus.stat_rejects),  m_rejects);
    check("stat_timeouts", int'(bus.stat_timeouts), m_timeouts);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Waits for a response pulse; 1=entry_ack 2=entry_reject 3=exit_ack 4=err_exit.
  task automatic wait_resp(output int kind, output int cycles);
    kind = 0;
    cycles = 0;
    for (int c = 0; c < 300 && kind == 0; c++) begin
      @(negedge clk);
      cycles++;
      if (bus.entry_ack) kind = 1;
      else if (bus.entry_reject) kind = 2;
      else if (bus.exit_ack) kind = 3;
      else if (bus.err_exit) kind = 4;
    end
    #1;
    if (kind == 1 || kind == 2) bus.entry_req = 1'b0;
    if (kind == 3 || kind == 4) bus.exit_req = 1'b0;
    if (kind == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_resp: no response pulse within 300 cycles");
    end
  endtask

  task automatic pulse_car();
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
  endtask

  task automatic enter_car(input bit pass, output int kind);
    int cyc;
    bus.entry_req = 1'b1;
    wait_resp(kind, cyc);
    if (kind == 1 && pass) pulse_car();
  endtask

  task automatic exit_car(input int slot, input bit pass, output int kind);
    int cyc;
    bus.exit_slot = SLOT_W'(slot);
    bus.exit_req  = 1'b1;
    wait_resp(kind, cyc);
    if (kind == 3 && pass) pulse_car();
  endtask

  task automatic do_reset();
    bus.entry_req = 0; bus.exit_req = 0; bus.car_passed = 0; bus.exit_slot = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, cyc, n, car_rate;
    int exp_slots[3];
    exp_slots[0] = 0; exp_slots[1] = 3; exp_slots[2] = 5;
    bus.entry_req = 0; bus.exit_req = 0; bus.car_passed = 0; bus.exit_slot = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    check("rst occupancy",  int'(bus.occupancy), 0);
    check("rst free_count", int'(bus.free_count), 8);
    check("rst full",       int'(bus.full), 0);
    check("rst gate_open",  int'(bus.gate_open), 0);
    check("rst busy",       int'(bus.busy), 0);

    // First entry: ack one cycle after the request, slot 0
    bus.entry_req = 1'b1;
    wait_resp(kind, cyc);
    check("t1 kind", kind, 1);
    check("t1 latency", cyc, 1);
    check("t1 assigned_slot", int'(bus.assigned_slot), 0);
    check("t1 occupancy", int'(bus.occupancy), 8'h01);
    check("t1 free_count", int'(bus.free_count), 7);
    check("t1 gate open", int'(bus.gate_open), 1);
    repeat (3) tick();
    pulse_car();
    check("t1 gate closed", int'(bus.gate_open), 0);
    check("t1 occupancy kept", int'(bus.occupancy), 8'h01);

    // Fill, then drain slots 0,3,5 to reach 8'b11010110
    for (int i = 1; i < NUM_SLOTS; i++) enter_car(1'b1, kind);
    check("t2 all full", int'(bus.full), 1);
    exit_car(0, 1'b1, kind);
    exit_car(3, 1'b1, kind);
    exit_car(5, 1'b1, kind);
    check("t2 preload", int'(bus.occupancy), 8'hD6);
    check("t2 preload free", int'(bus.free_count), 3);
    for (int i = 0; i < 3; i++) begin
      enter_car(1'b1, kind);
      check("t2 kind", kind, 1);
      check("t2 assigned_slot", int'(bus.assigned_slot), exp_slots[i]);
    end
    check("t2 full", int'(bus.full), 1);
    enter_car(1'b1, kind);
    check("t2 reject kind", kind, 2);
    check("t2 reject gate", int'(bus.gate_open), 0);
    check("t2 reject occupancy", int'(bus.occupancy), 8'hFF);

    // Simultaneous requests: exit first, then held entry, then exit again
    do_reset();
    for (int i = 0; i < 3; i++) enter_car(1'b1, kind);
    bus.exit_slot = SLOT_W'(2);
    bus.exit_req  = 1'b1;
    bus.entry_req = 1'b1;
    wait_resp(kind, cyc);
    check("t3 first served", kind, 3);
    pulse_car();
    wait_resp(kind, cyc);
    check("t3 held entry served", kind, 1);
    check("t3 entry slot", int'(bus.assigned_slot), 2);
    pulse_car();
    bus.exit_slot = SLOT_W'(0);
    bus.exit_req  = 1'b1;
    bus.entry_req = 1'b1;
    wait_resp(kind, cyc);
    check("t3 second pair exit first", kind, 3);
    pulse_car();
    wait_resp(kind, cyc);
    check("t3 second entry", kind, 1);
    check("t3 second entry slot", int'(bus.assigned_slot), 0);
    pulse_car();
    check("t3 occupancy", int'(bus.occupancy), 8'h07);

    // Entry timeout: gate open exactly GATE_TIMEOUT cycles, slot rolled back
    bus.entry_req = 1'b1;
    wait_resp(kind, cyc);
    check("t4 kind", kind, 1);
    check("t4 slot", int'(bus.assigned_slot), 3);
    n = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!bus.gate_open) break;
      n++;
    end
    #1;
    check("t4 open cycles", n, 100);
    check("t4 occupancy rolled back", int'(bus.occupancy), 8'h07);
    check("t4 free_count", int'(bus.free_count), 5);
    check("t4 busy", int'(bus.busy), 0);

    // Exit of an empty slot
    do_reset();
    enter_car(1'b1, kind);
    exit_car(7, 1'b1, kind);
    check("t5 kind", kind, 4);
    check("t5 gate", int'(bus.gate_open), 0);
    check("t5 occupancy", int'(bus.occupancy), 8'h01);

    // Asynchronous reset while in ENTRY_GATE with a full lot
    for (int i = 1; i < NUM_SLOTS - 1; i++) enter_car(1'b1, kind);
    enter_car(1'b0, kind);
    check("t6 pre occupancy", int'(bus.occupancy), 8'hFF);
    check("t6 pre busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6 gate_open", int'(bus.gate_open), 0);
    check("t6 occupancy", int'(bus.occupancy), 0);
    check("t6 busy", int'(bus.busy), 0);
    check("t6 free_count", int'(bus.free_count), 8);
`ifdef PARK_GATE_STATS_EN
    check("t6 stat_entries", int'(bus.stat_entries), 0);
    check("t6 stat_rejects", int'(bus.stat_rejects), 0);
    check("t6 stat_timeouts", int'(bus.stat_timeouts), 0);
`endif
    rst_n = 1'b1;

    // Randomized lane traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      car_rate = ((c / 500) % 2 == 1) ? 150 : 8;
      if (bus.entry_req && (bus.entry_ack || bus.entry_reject)) bus.entry_req = 1'b0;
      else if (!bus.entry_req && $urandom_range(0, 3) == 0) bus.entry_req = 1'b1;
      if (bus.exit_req && (bus.exit_ack || bus.err_exit)) bus.exit_req = 1'b0;
      else if (!bus.exit_req && $urandom_range(0, 4) == 0) begin
        bus.exit_slot = SLOT_W'($urandom_range(0, NUM_SLOTS - 1));
        bus.exit_req  = 1'b1;
      end
      bus.car_passed = ($urandom_range(0, car_rate - 1) == 0);
    end
    bus.entry_req = 0; bus.exit_req = 0; bus.car_passed = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
